// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the {CO,SUM} accumulator slice.
package sum_acc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / total-out handshake bundle between the adder stream, the accumulator and its consumer.
interface sum_accumulator_if #(
    parameter int unsigned DATA_W = sum_acc_pkg::DATA_W,
    parameter int unsigned ACC_W  = sum_acc_pkg::ACC_W,
    parameter int unsigned CNT_W  = sum_acc_pkg::CNT_W
);
    logic              start;
    logic [CNT_W-1:0]  num;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic              in_co;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;
    logic              busy;

    modport master (
        output start, num, in_valid, in_sum, in_co, out_ready,
        input  in_ready, out_valid, acc_out, ovf, busy
    );

    modport slave (
        input  start, num, in_valid, in_sum, in_co, out_ready,
        output in_ready, out_valid, acc_out, ovf, busy
    );

endinterface

// File: rtl/sum_acc_fsm.sv
// Run control: IDLE -> ACC -> DONE sequencing, sample counter and registered handshake flags.
module sum_acc_fsm #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             busy,
    output logic             clear_c,
    output logic             take_c
);
    import sum_acc_pkg::*;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             in_ready_nxt, out_valid_nxt, busy_nxt;

    // State, counter and flags all update together so the flags track the state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        clear_c       = 1'b0;
        take_c        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_c = 1'b1;
                    if (num != '0) begin
                        cnt_nxt      = num;
                        state_nxt    = ACC;
                        in_ready_nxt = 1'b1;
                    end else begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            ACC: begin
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    take_c  = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt     = DONE;
                        in_ready_nxt  = 1'b0;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                out_valid_nxt = 1'b1;
                if (out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmed count of 17-bit {CO,SUM} adder results and presents the total with a sticky overflow flag.
// Define SUM_ACC_SAT_EN to clamp the total at all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned DATA_W = sum_acc_pkg::DATA_W,
    parameter int unsigned ACC_W  = sum_acc_pkg::ACC_W,
    parameter int unsigned CNT_W  = sum_acc_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    sum_accumulator_if.slave    bus
);
    localparam int unsigned SUM_W = ACC_W + 1;

    logic              clear_c, take_c;
    logic [DATA_W:0]   sample;
    logic [SUM_W-1:0]  sum_c;
    logic [ACC_W-1:0]  acc;
    logic              ovf;

    sum_acc_fsm #(.CNT_W(CNT_W)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .num       (bus.num),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .busy      (bus.busy),
        .clear_c   (clear_c),
        .take_c    (take_c)
    );

    // One extra bit so the carry out of the accumulator is visible.
    assign sample = {bus.in_co, bus.in_sum};
    assign sum_c  = {1'b0, acc} + SUM_W'(sample);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear_c) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (take_c) begin
            if (sum_c[ACC_W]) begin
                ovf <= 1'b1;
`ifdef SUM_ACC_SAT_EN
                // Once clamped, every further non-zero sample carries again, so it stays clamped.
                acc <= '1;
`else
                acc <= sum_c[ACC_W-1:0];
`endif
            end else begin
                acc <= sum_c[ACC_W-1:0];
            end
        end
    end

    assign bus.acc_out = acc;
    assign bus.ovf     = ovf;

endmodule
